hilo_multdiv: RTL and testbench
===============================

Name: hilo_multdiv

Overview:
Multi-cycle signed multiply/divide unit that produces the Hi and Lo registers consumed by the ALU-output select mux (Hi/Lo sources). Executes MIPS MULT/DIV semantics iteratively, one bit per cycle, under control of the main control FSM. Hi/Lo are architectural registers held in this block; they change only when an operation completes.

Parameters:
WIDTH, 32, operand/Hi/Lo width; iteration count equals WIDTH.
CNT_W, 6, counter width; must hold WIDTH.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request; sampled only in IDLE
op  input  1  0 = MULT (signed), 1 = DIV (signed)
a  input  WIDTH  rs operand (multiplicand / dividend)
b  input  WIDTH  rt operand (multiplier / divisor)
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; Hi/Lo valid from this cycle
div_zero  output  1  high with done when DIV had b == 0
hi  output  WIDTH  Hi register
lo  output  WIDTH  Lo register

Behaviour:
- Reset (async, active-high): state=IDLE; hi=0, lo=0, busy=0, done=0, div_zero=0; counter and datapath registers cleared. Reset mid-operation aborts; Hi/Lo return to 0.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE: on start=1, latch a, b, op; counter=WIDTH.
  - op=0 -> MUL.
  - op=1, b!=0 -> DIV.
  - op=1, b==0 -> DONE with div_zero=1; hi/lo unchanged.
- MUL: radix-2 Booth on product register {P_hi[WIDTH], P_lo[WIDTH], q_-1}. Per cycle:
  - If {P_lo[0], q_-1} = 01, add multiplicand to P_hi; if 10, subtract it.
  - Then arithmetic shift right by 1.
  - Counter decrements; at 0 -> FIX.
- DIV: unsigned restoring division on |a|, |b|. Signs are recorded at start; |-2^31| = 0x80000000 treated as unsigned. Per cycle: shift {R,Q} left by 1, trial-subtract |b| from R, keep the result if non-negative and set Q[0]=1. Counter at 0 -> FIX.
- FIX (1 cycle):
  - MUL: hi=P_hi, lo=P_lo.
  - DIV: lo = quotient, negated if sign(a)!=sign(b); hi = remainder, negated if a<0. Truncation toward zero.
  - Then -> DONE.
- DONE (1 cycle): done=1 (div_zero per case). -> IDLE.
- Latency: MULT/DIV start at edge 0; hi/lo update at edge WIDTH+1 (33); done high in the cycle after edge 33, so 34 cycles start-to-done. Div-by-zero: done in the cycle after edge 0.
- busy=1 from the edge that accepts start until DONE exits.
- start while busy: ignored, not queued.
- start in the DONE cycle: ignored; a new op is accepted only in IDLE.
- Overflow: -2^31 / -1 gives lo=0x80000000, hi=0, no flag.
- MULT: full 2·WIDTH product, no overflow.
- Hi/Lo stay stable while busy (the mux may read stale values until done).

Decomposition:
- Shared package/header (`define include): state encodings; OP_MULT=1'b0, OP_DIV=1'b1.
- One sub-module is natural: booth_step (combinational add/sub plus arithmetic shift of the product register). The divider step stays inline. FSM and counter live in hilo_multdiv.

Test Plan:
- MULT a=7, b=0xFFFFFFFD (-3) -> done at cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high on cycles 1-34.
- MULT a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000; then MULT 0xFFFFFFFF x 0xFFFFFFFF -> hi=0, lo=1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 7/-2 -> lo=0xFFFFFFFD, hi=1; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Preload hi/lo via MULT 3x5 (lo=15); DIV a=9, b=0 -> done and div_zero on cycle 1; hi=0, lo=15 unchanged.
- Start MULT 3x5; pulse start with DIV 100/7 at cycle 10 -> ignored; result lo=15, hi=0 at cycle 34.
- Start DIV 100/7; assert reset at cycle 12 -> busy=0, hi=lo=0 immediately. After release, DIV 100/7 -> lo=14, hi=2.

Source files
------------

// File: rtl/hilo_multdiv_pkg.sv
// Shared encodings for the Hi/Lo multiply/divide unit: FSM states and opcode values.
package hilo_multdiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/hilo_multdiv_if.sv
// Request/result bundle between the control FSM (master) and the Hi/Lo unit (slave).
interface hilo_multdiv_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );

endinterface

// File: rtl/hilo_multdiv_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand into the
// upper half, then arithmetic shift right of {p_hi, p_lo, q_-1}.
module hilo_multdiv_booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] p_hi_i,
  input  logic [WIDTH-1:0] p_lo_i,
  input  logic             q_m1_i,
  output logic [WIDTH-1:0] p_hi_o,
  output logic [WIDTH-1:0] p_lo_o,
  output logic             q_m1_o
);

  logic [WIDTH:0] ext_hi_s;
  logic [WIDTH:0] ext_mc_s;
  logic [WIDTH:0] sum_s;

  // Sum is one bit wider so the sign survives an overflowing add/sub before the shift.
  always_comb begin
    ext_hi_s = {p_hi_i[WIDTH-1], p_hi_i};
    ext_mc_s = {mcand_i[WIDTH-1], mcand_i};
    case ({p_lo_i[0], q_m1_i})
      2'b01:   sum_s = ext_hi_s + ext_mc_s;
      2'b10:   sum_s = ext_hi_s - ext_mc_s;
      default: sum_s = ext_hi_s;
    endcase
    p_hi_o = sum_s[WIDTH:1];
    p_lo_o = {sum_s[0], p_lo_i[WIDTH-1:1]};
    q_m1_o = p_lo_i[0];
  end

endmodule

// File: rtl/hilo_multdiv.sv
// Iterative signed MULT/DIV unit holding the architectural Hi/Lo registers.
// One bit per cycle; Hi/Lo are written only in the FIX state.
module hilo_multdiv
  import hilo_multdiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          reset,
  hilo_multdiv_if.slave bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_q, op_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   low_q, low_d;
  logic               qm1_q, qm1_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               div_zero_q, div_zero_d;

  logic [WIDTH-1:0]   booth_hi_s;
  logic [WIDTH-1:0]   booth_lo_s;
  logic               booth_qm1_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_diff_s;
  logic [WIDTH-1:0]   div_rem_s;
  logic [WIDTH-1:0]   div_quo_s;

  // The most negative value maps to itself, which reads correctly as unsigned 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  hilo_multdiv_booth_step #(.WIDTH(WIDTH)) u_booth (
    .mcand_i (mcand_q),
    .p_hi_i  (acc_q),
    .p_lo_i  (low_q),
    .q_m1_i  (qm1_q),
    .p_hi_o  (booth_hi_s),
    .p_lo_o  (booth_lo_s),
    .q_m1_o  (booth_qm1_s)
  );

  // Restoring-division step: acc holds the partial remainder, low shifts dividend out and quotient in.
  always_comb begin
    div_shift_s = {acc_q, low_q[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, mcand_q};
    if (!div_diff_s[WIDTH]) begin
      div_rem_s = div_diff_s[WIDTH-1:0];
      div_quo_s = {low_q[WIDTH-2:0], 1'b1};
    end else begin
      div_rem_s = div_shift_s[WIDTH-1:0];
      div_quo_s = {low_q[WIDTH-2:0], 1'b0};
    end
  end

  // Next-state and datapath update for the control FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    low_d      = low_q;
    qm1_d      = qm1_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_d  = bus.op;
          cnt_d = CNT_W'(WIDTH);
          acc_d = '0;
          qm1_d = 1'b0;
          if (bus.op == OP_MULT) begin
            mcand_d   = bus.a;
            low_d     = bus.b;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = ST_MUL;
          end else if (bus.b == '0) begin
            div_zero_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            mcand_d   = magnitude(bus.b);
            low_d     = magnitude(bus.a);
            neg_quo_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            neg_rem_d = bus.a[WIDTH-1];
            state_d   = ST_DIV;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        acc_d = booth_hi_s;
        low_d = booth_lo_s;
        qm1_d = booth_qm1_s;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_DIV: begin
        acc_d = div_rem_s;
        low_d = div_quo_s;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_DIV;
        end
      end
      ST_FIX: begin
        if (op_q == OP_MULT) begin
          hi_d = acc_q;
          lo_d = low_q;
        end else begin
          lo_d = neg_quo_q ? -low_q : low_q;
          hi_d = neg_rem_q ? -acc_q : acc_q;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter, datapath and Hi/Lo registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= 1'b0;
      mcand_q    <= '0;
      acc_q      <= '0;
      low_q      <= '0;
      qm1_q      <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      mcand_q    <= mcand_d;
      acc_q      <= acc_d;
      low_q      <= low_d;
      qm1_q      <= qm1_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_hilo_multdiv.sv
// Randomised and directed bench for hilo_multdiv against a cycle-timed arithmetic model.
module tb_hilo_multdiv;

  localparam int W = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   cmp_en   = 1'b0;

  hilo_multdiv_if #(.WIDTH(W)) bus ();

  hilo_multdiv #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Architectural result by plain 64-bit arithmetic; returns {hi, lo}.
  function automatic logic [63:0] ref_result(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa;
    longint sb;
    longint p;
    longint q;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 1'b0) begin
      p = sa * sb;
      return p[63:0];
    end else begin
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Timing model: an accepted op makes Hi/Lo visible and done high 34 cycles later; div-by-zero completes next cycle.
  logic          m_busy = 1'b0;
  logic          m_done = 1'b0;
  logic          m_dz   = 1'b0;
  logic [W-1:0]  m_hi   = '0;
  logic [W-1:0]  m_lo   = '0;
  logic [63:0]   m_res  = '0;
  int            m_cnt  = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
      m_hi <= '0; m_lo <= '0; m_cnt <= 0;
    end else begin
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      if (!m_busy) begin
        if (bus.start) begin
          m_busy <= 1'b1;
          if (bus.op && bus.b == '0) begin
            m_done <= 1'b1; m_dz <= 1'b1; m_cnt <= 0;
          end else begin
            m_res <= ref_result(bus.op, bus.a, bus.b);
            m_cnt <= W + 1;
          end
        end
      end else if (m_cnt == 0) begin
        m_busy <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_hi <= m_res[63:32]; m_lo <= m_res[31:0]; m_done <= 1'b1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      check("busy", 64'(bus.busy), 64'(m_busy));
      check("done", 64'(bus.done), 64'(m_done));
      check("div_zero", 64'(bus.div_zero), 64'(m_dz));
      check("hi", 64'(bus.hi), 64'(m_hi));
      check("lo", 64'(bus.lo), 64'(m_lo));
    end
  end

  task automatic do_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit lit, input logic [W-1:0] eh, input logic [W-1:0] el);
    bit seen;
    int n;
    int exp_cyc;
    exp_cyc = (op && b == '0) ? 1 : 34;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    seen = 1'b0; n = 0;
    for (int i = 1; i <= 100 && !seen; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) begin seen = 1'b1; n = i; end
    end
    check("done_seen", 64'(seen), 64'd1);
    check("latency", 64'(n), 64'(exp_cyc));
    check("done_dz", 64'(bus.div_zero), 64'(op && b == '0));
    if (lit) begin
      check("lit_hi", 64'(bus.hi), 64'(eh));
      check("lit_lo", 64'(bus.lo), 64'(el));
      check("model_hi", 64'(m_hi), 64'(eh));
      check("model_lo", 64'(m_lo), 64'(el));
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    bit seen;
    int n;
    bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_dz", 64'(bus.div_zero), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    reset = 1'b0;
    cmp_en = 1'b1;

    do_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    do_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000);
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0001);
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'h0000_0001, 32'hFFFF_FFFD);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000);
    do_op(1'b0, 32'd3, 32'd5, 1'b1, 32'd0, 32'd15);
    do_op(1'b1, 32'd9, 32'd0, 1'b1, 32'd0, 32'd15);

    // Start while busy and start during DONE must both be dropped.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'd3; bus.b = 32'd5;
    seen = 1'b0; n = 0;
    for (int i = 1; i <= 100 && !seen; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (i == 10) begin bus.start = 1'b1; bus.op = 1'b1; bus.a = 32'd100; bus.b = 32'd7; end
      if (bus.done) begin
        seen = 1'b1; n = i;
        bus.start = 1'b1; bus.op = 1'b1; bus.a = 32'd9; bus.b = 32'd0;
      end
    end
    check("ign_seen", 64'(seen), 64'd1);
    check("ign_latency", 64'(n), 64'd34);
    check("ign_lo", 64'(bus.lo), 64'd15);
    check("ign_hi", 64'(bus.hi), 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    check("ign_done_start", 64'(bus.busy), 64'd0);

    // Reset mid-division aborts and clears Hi/Lo at once.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b1; bus.a = 32'd100; bus.b = 32'd7;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    reset = 1'b1;
    #1;
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_hi", 64'(bus.hi), 64'd0);
    check("arst_lo", 64'(bus.lo), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    do_op(1'b1, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);

    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = pick_operand();
      rb = pick_operand();
      do_op(1'($urandom_range(0, 1)), ra, rb, 1'b0, '0, '0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
